// File: rtl/i_ram_loader_pkg.sv
// Shared definitions for the i_ram serial boot loader.
//   state_t        : loader frame-parser states
//   START_BYTE_DEF : default frame start marker
//   tmo_width()    : width of the inter-byte timeout counter (never below 17)
package i_ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHK     = 3'd5
  } state_t;

  localparam logic [7:0] START_BYTE_DEF = 8'hA5;

  function automatic int tmo_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    return (w < 17) ? 17 : w;
  endfunction

endpackage

// File: rtl/i_ram_loader_if.sv
// Byte-stream input and i_ram write port of the boot loader.
//   rx_data/rx_valid/rx_ready : byte stream from uart_rx (consumed on valid&ready)
//   w_addr/din/w_en           : i_ram write port
// Modports:
//   master : stream source / RAM side (drives bytes, observes writes)
//   slave  : the loader (consumes bytes, drives writes)
interface i_ram_loader_if #(
  parameter int addr_width = 12,
  parameter int data_width = 16
) ();
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [addr_width-1:0] w_addr;
  logic [data_width-1:0] din;
  logic                  w_en;

  modport master (output rx_data, rx_valid, input rx_ready, w_addr, din, w_en);
  modport slave  (input rx_data, rx_valid, output rx_ready, w_addr, din, w_en);
endinterface

// File: rtl/i_ram_loader.sv
// Serial boot loader for the instruction RAM.
// Parses START, LEN_HI, LEN_LO, LEN x {hi, lo}, CHK from the byte stream,
// writes each 16-bit word into i_ram and holds the CPU in reset while loading.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : byte stream in + i_ram write port (slave modport)
//   cpu_rst   : hold CPU in reset (set on START, cleared only by a good frame)
//   busy      : frame in progress
//   load_done : one-cycle pulse after a good checksum
//   load_err  : sticky error, cleared when the next START is accepted
module i_ram_loader
  import i_ram_loader_pkg::*;
#(
  parameter int         addr_width  = 12,
  parameter int         data_width  = 16,
  parameter logic [7:0] START_BYTE  = START_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  i_ram_loader_if.slave     bus,
  output logic              cpu_rst,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int          TW    = tmo_width(TIMEOUT_CYC);
  // Legal length ceiling is the full RAM depth, so 17 bits are needed.
  localparam logic [16:0] DEPTH = 17'(1) << addr_width;

  state_t                state_q, state_n;
  logic [7:0]            hi_q, hi_n;      // LEN_HI, then each data hi byte
  logic [addr_width-1:0] addr_q, addr_n;
  logic [15:0]           rem_q, rem_n;
  logic [7:0]            chk_q, chk_n;
  logic [TW-1:0]         tmo_q, tmo_n;
  logic                  w_en_q, w_en_n;
  logic [addr_width-1:0] w_addr_q, w_addr_n;
  logic [data_width-1:0] din_q, din_n;
  logic                  cpu_rst_q, cpu_rst_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;

  logic       take;
  logic [7:0] b;
  logic [15:0] len;

  assign take = bus.rx_valid;   // always ready
  assign b    = bus.rx_data;

  always_comb begin
    state_n   = state_q;
    hi_n      = hi_q;
    addr_n    = addr_q;
    rem_n     = rem_q;
    chk_n     = chk_q;
    tmo_n     = '0;
    w_en_n    = 1'b0;
    w_addr_n  = w_addr_q;
    din_n     = din_q;
    cpu_rst_n = cpu_rst_q;
    done_n    = 1'b0;
    err_n     = err_q;
    len       = {hi_q, b};

    if (take) begin
      // An accepted byte always wins over timeout expiry; tmo_n stays 0.
      unique case (state_q)
        IDLE: if (b == START_BYTE) begin
          state_n   = LEN_HI;
          cpu_rst_n = 1'b1;
          err_n     = 1'b0;
          chk_n     = '0;
          addr_n    = '0;
        end
        LEN_HI: begin
          hi_n    = b;
          chk_n   = chk_q ^ b;
          state_n = LEN_LO;
        end
        LEN_LO: begin
          chk_n = chk_q ^ b;
          rem_n = len;
          if ({1'b0, len} > DEPTH) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else if (len == 16'd0) begin
            state_n = CHK;
          end else begin
            state_n = DATA_HI;
          end
        end
        DATA_HI: begin
          hi_n    = b;
          chk_n   = chk_q ^ b;
          state_n = DATA_LO;
        end
        DATA_LO: begin
          chk_n    = chk_q ^ b;
          w_en_n   = 1'b1;
          w_addr_n = addr_q;
          din_n    = data_width'({hi_q, b});
          addr_n   = addr_q + 1'b1;   // wraps harmlessly after the last word
          rem_n    = rem_q - 16'd1;
          state_n  = (rem_q == 16'd1) ? CHK : DATA_HI;
        end
        CHK: begin
          if (b == chk_q) begin
            cpu_rst_n = 1'b0;
            done_n    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // cpu_rst is deliberately left set: RAM holds a partial image.
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        err_n   = 1'b1;
        state_n = IDLE;
      end else begin
        tmo_n = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      din_q     <= '0;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      hi_q      <= hi_n;
      addr_q    <= addr_n;
      rem_q     <= rem_n;
      chk_q     <= chk_n;
      tmo_q     <= tmo_n;
      w_en_q    <= w_en_n;
      w_addr_q  <= w_addr_n;
      din_q     <= din_n;
      cpu_rst_q <= cpu_rst_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  assign bus.rx_ready = 1'b1;
  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.din      = din_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = (state_q != IDLE);
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule
